// File: rtl/nvdla_csb2apb.sv
// nvdla_csb2apb: CSB-to-APB3 master bridge.
// Accepts one CSB register request at a time, runs it as an APB3 transfer and
// returns read data / non-posted write completions on the CSB response channel.
// An ACCESS-phase timeout keeps a hung slave from locking up the CSB.
//
// Ports:
//   pclk, prstn                  clock, asynchronous active-low reset
//   csb2apb_valid/ready          request handshake (ready only in IDLE)
//   csb2apb_addr/wdat/write/nposted  request payload (word address)
//   apb2csb_valid/data           read response pulse and data
//   apb2csb_wr_complete          non-posted write completion pulse
//   apb2csb_error                error qualifier for either pulse
//   psel/penable/pwrite/paddr/pwdata  APB3 master outputs
//   prdata/pready/pslverr        APB3 slave inputs
module nvdla_csb2apb #(
  parameter logic [31:0] APB_BASE       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        pclk,
  input  logic        prstn,
  input  logic        csb2apb_valid,
  output logic        csb2apb_ready,
  input  logic [15:0] csb2apb_addr,
  input  logic [31:0] csb2apb_wdat,
  input  logic        csb2apb_write,
  input  logic        csb2apb_nposted,
  output logic        apb2csb_valid,
  output logic [31:0] apb2csb_data,
  output logic        apb2csb_wr_complete,
  output logic        apb2csb_error,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [15:0]      addr_q;
  logic [31:0]      wdat_q;
  logic             write_q;
  logic             nposted_q;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             timeout;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // psel/penable/ready decode from state alone so an async reset drops them at once.
  always_comb begin
    state_nxt     = state;
    csb2apb_ready = 1'b0;
    psel          = 1'b0;
    penable       = 1'b0;
    done          = 1'b0;
    timeout       = 1'b0;
    case (state)
      IDLE: begin
        csb2apb_ready = 1'b1;
        if (csb2apb_valid) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready takes priority over a timeout expiring in the same cycle.
        if (pready) begin
          done = 1'b1;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request holding registers; they also drive the APB address/data so those
  // stay put through the transfer and in IDLE.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      addr_q    <= '0;
      wdat_q    <= '0;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
    end else if (state == IDLE && csb2apb_valid) begin
      addr_q    <= csb2apb_addr;
      wdat_q    <= csb2apb_wdat;
      write_q   <= csb2apb_write;
      nposted_q <= csb2apb_nposted;
    end
  end

  assign paddr  = APB_BASE | {14'b0, addr_q, 2'b00};
  assign pwdata = wdat_q;
  assign pwrite = write_q;

  // Wait-state counter: counts stalled ACCESS cycles, saturates, clears otherwise.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      cnt <= '0;
    end else if (state == ACCESS && !done) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Registered single-cycle response; posted writes never respond.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      apb2csb_valid       <= 1'b0;
      apb2csb_wr_complete <= 1'b0;
      apb2csb_error       <= 1'b0;
      apb2csb_data        <= '0;
    end else begin
      apb2csb_valid       <= done && !write_q;
      apb2csb_wr_complete <= done && write_q && nposted_q;
      apb2csb_error       <= done && (!write_q || nposted_q) && (timeout || pslverr);
      if (done && !write_q) apb2csb_data <= timeout ? 32'h0 : prdata;
    end
  end

endmodule

// File: doc/nvdla_csb2apb.md
Name: nvdla_csb2apb

Overview:
- CSB-to-APB master bridge; the opposite direction of the existing APB-to-CSB slave bridge.
- Accepts single CSB register requests (valid/ready, 16-bit word address, posted/non-posted) and runs them as APB3 transfers to a downstream peripheral.
- Returns read data and non-posted write completions on the CSB response channel.
- One outstanding transaction at a time; includes an access-phase timeout so a hung slave cannot lock up the CSB.

Parameters:
- APB_BASE, 32'h0000_0000, OR'ed into generated paddr; bits [17:0] must be zero.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock.
- prstn  in  1  asynchronous active-low reset.
- csb2apb_valid  in  1  CSB request valid.
- csb2apb_ready  out  1  CSB request ready.
- csb2apb_addr  in  16  CSB word address.
- csb2apb_wdat  in  32  write data.
- csb2apb_write  in  1  1 = write, 0 = read.
- csb2apb_nposted  in  1  write requires completion.
- apb2csb_valid  out  1  read-data response pulse.
- apb2csb_data  out  32  read data.
- apb2csb_wr_complete  out  1  non-posted write completion pulse.
- apb2csb_error  out  1  response carries error; qualifies either pulse.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  32  APB byte address.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0, except csb2apb_ready = 1; state = IDLE; timeout counter = 0.
- Reset asserted mid-transfer drops psel/penable immediately; the transfer is lost and no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - csb2apb_ready = 1 (combinational from state only, not from valid).
  - On valid & ready, capture addr, wdat, write and nposted into holding registers and go to SETUP.
- SETUP: psel = 1, penable = 0; always exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; counter increments each cycle pready = 0.
  - On pready = 1, capture prdata and pslverr, go to IDLE and clear the counter.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with pready = 0, abort: drop psel/penable, go to IDLE, and respond with error = 1 and data = 0.
  - pready and the timeout expiring in the same cycle: pready wins.
- APB signals:
  - paddr = APB_BASE | {14'b0, addr, 2'b00}.
  - pwrite, paddr and pwdata are held stable from SETUP through the end of ACCESS.
  - pwrite, paddr and pwdata keep their last value in IDLE (no toggling).
- Response rules (registered, one cycle after the completing ACCESS cycle, single-cycle pulse, no backpressure):
  - Read: apb2csb_valid = 1 and apb2csb_data = captured prdata (0 on timeout).
  - Write with nposted = 1: apb2csb_wr_complete = 1.
  - Posted write: no pulse at all, including on pslverr or timeout.
  - apb2csb_error = pslverr, or 1 on timeout; it is valid only while a pulse is high and is 0 otherwise.
  - apb2csb_data holds its value when no pulse is present.
- Latency:
  - With the request accepted at cycle T: SETUP at T+1, ACCESS at T+2; with pready = 1 at T+2 the response appears at T+3.
  - csb2apb_ready is 1 again at T+3, so a back-to-back accept at T+3 overlaps the response cycle.
- csb2apb_valid dropping while ready = 0 is ignored; the request is captured only on the handshake.
- Counter width: clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.

Test Plan:
- Read, addr 16'h0123, APB_BASE 0, slave pready = 1 on first ACCESS, prdata = 32'hCAFE_F00D → paddr = 32'h0000_048C; psel at T+1 and penable at T+2; apb2csb_valid = 1 with data = 32'hCAFE_F00D and error = 0 at T+3 only.
- Non-posted write, addr 16'h0010, wdat = 32'h1234_5678, pready delayed 3 cycles → pwdata/paddr stable for 4 ACCESS cycles; wr_complete pulse 1 cycle after pready; apb2csb_valid stays 0.
- Posted write with pslverr = 1 → APB transfer completes normally; no response pulse of any kind.
- TIMEOUT_CYCLES = 4, read, pready held at 0 → penable high for exactly 4 cycles then psel drops; apb2csb_valid = 1 with error = 1 and data = 0; next request accepted afterwards.
- Back-to-back requests with valid held high → second handshake on the response cycle of the first; no cycle where psel is high while the FSM is in IDLE.
- prstn asserted during ACCESS → psel, penable and all responses go to 0 asynchronously; after release ready = 1 and no stale response is issued.
